// File: rtl/fix_field_scanner_if.sv
// Ingress/egress bus bundle for fix_field_scanner (valid/ready on both sides).
// Carries chksum_o only when FIX_SCAN_CHECKSUM_EN is defined.
interface fix_field_scanner_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 16
);
    localparam int unsigned IDX_W = $clog2(LANES) + 1;

    logic [8*LANES-1:0] data_i;
    logic [LANES-1:0]   keep_i;
    logic               valid_i;
    logic               ready_o;
    logic               valid_o;
    logic               ready_i;
    logic [LANES-1:0]   soh_mask_o;
    logic [LANES-1:0]   sep_mask_o;
    logic [IDX_W-1:0]   soh_idx_o;
    logic [IDX_W-1:0]   sep_idx_o;
    logic [LANES-1:0]   tag_mask_o;
    logic [LANES-1:0]   val_mask_o;
    logic               tag_vld_o;
    logic [TAG_W-1:0]   tag_o;
    logic [IDX_W-1:0]   tag_cnt_o;
    logic               tag_status_o;
    logic               body_status_o;
    logic               err_o;
`ifdef FIX_SCAN_CHECKSUM_EN
    logic [7:0]         chksum_o;
`endif

    modport slave (
        input  data_i, keep_i, valid_i, ready_i,
        output ready_o, valid_o, soh_mask_o, sep_mask_o, soh_idx_o, sep_idx_o,
               tag_mask_o, val_mask_o, tag_vld_o, tag_o, tag_cnt_o,
               tag_status_o, body_status_o, err_o
`ifdef FIX_SCAN_CHECKSUM_EN
        , output chksum_o
`endif
    );

    modport master (
        output data_i, keep_i, valid_i, ready_i,
        input  ready_o, valid_o, soh_mask_o, sep_mask_o, soh_idx_o, sep_idx_o,
               tag_mask_o, val_mask_o, tag_vld_o, tag_o, tag_cnt_o,
               tag_status_o, body_status_o, err_o
`ifdef FIX_SCAN_CHECKSUM_EN
        , input chksum_o
`endif
    );
endinterface

// File: rtl/fix_field_scanner.sv
// FIX field scanner: per-beat SOH/"=" detection, TAG/VALUE classification and tag decode.
// Optional running byte checksum (reset after each tag-10 field) via FIX_SCAN_CHECKSUM_EN.
module fix_field_scanner #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned TAG_W    = 16,
    parameter logic [7:0]  SOH_CHAR = 8'h01,
    parameter logic [7:0]  SEP_CHAR = 8'h3D
) (
    input  logic              clk,
    input  logic              rst,
    fix_field_scanner_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(LANES) + 1;
    localparam int unsigned MUL_W = TAG_W + 4;
    localparam logic [IDX_W-1:0] IDX_NONE = '1;

    typedef enum logic {
        ST_TAG   = 1'b0,
        ST_VALUE = 1'b1
    } state_t;

    // Carried parse context
    state_t             r_state;
    logic [TAG_W-1:0]   r_acc;
    logic               r_has_dig;
    logic               r_ovf;

    // Output stage
    logic               r_valid;
    logic [LANES-1:0]   r_soh_mask;
    logic [LANES-1:0]   r_sep_mask;
    logic [IDX_W-1:0]   r_soh_idx;
    logic [IDX_W-1:0]   r_sep_idx;
    logic [LANES-1:0]   r_tag_mask;
    logic [LANES-1:0]   r_val_mask;
    logic               r_tag_vld;
    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   r_tag_cnt;
    logic               r_err;

    // Lane-walk results
    state_t             w_state;
    logic [TAG_W-1:0]   w_acc;
    logic               w_has_dig;
    logic               w_ovf;
    logic [LANES-1:0]   w_soh_mask;
    logic [LANES-1:0]   w_sep_mask;
    logic [IDX_W-1:0]   w_soh_idx;
    logic [IDX_W-1:0]   w_sep_idx;
    logic [LANES-1:0]   w_tag_mask;
    logic [LANES-1:0]   w_val_mask;
    logic               w_tag_vld;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_tag_cnt;
    logic               w_err;
    logic [7:0]         w_byte;
    logic [MUL_W-1:0]   w_prod;
    logic               w_ready;
    logic               w_accept;

`ifdef FIX_SCAN_CHECKSUM_EN
    logic [7:0]         r_sum;
    logic               r_t10;
    logic [7:0]         w_sum;
    logic               w_t10;
`endif

    assign w_ready  = !r_valid || bus.ready_i;
    assign w_accept = bus.valid_i && w_ready;

    // Walk kept lanes in order, starting from the carried parse context
    always_comb begin
        w_state    = r_state;
        w_acc      = r_acc;
        w_has_dig  = r_has_dig;
        w_ovf      = r_ovf;
        w_soh_mask = '0;
        w_sep_mask = '0;
        w_soh_idx  = IDX_NONE;
        w_sep_idx  = IDX_NONE;
        w_tag_mask = '0;
        w_val_mask = '0;
        w_tag_vld  = 1'b0;
        w_tag      = '0;
        w_tag_cnt  = '0;
        w_err      = 1'b0;
        w_byte     = '0;
        w_prod     = '0;
`ifdef FIX_SCAN_CHECKSUM_EN
        w_sum      = r_sum;
        w_t10      = r_t10;
`endif
        for (int unsigned i = 0; i < LANES; i++) begin
            if (bus.keep_i[i]) begin
                w_byte = bus.data_i[8*i +: 8];
`ifdef FIX_SCAN_CHECKSUM_EN
                w_sum = w_sum + w_byte;
`endif
                if (w_byte == SOH_CHAR) begin
                    w_soh_mask[i] = 1'b1;
                    if (w_soh_idx == IDX_NONE) w_soh_idx = IDX_W'(i);
                end
                if (w_byte == SEP_CHAR) begin
                    w_sep_mask[i] = 1'b1;
                    if (w_sep_idx == IDX_NONE) w_sep_idx = IDX_W'(i);
                end

                if (w_state == ST_TAG) begin
                    if (w_byte >= 8'h30 && w_byte <= 8'h39) begin
                        w_tag_mask[i] = 1'b1;
                        w_prod    = MUL_W'(w_acc) * MUL_W'(10) + MUL_W'(w_byte - 8'h30);
                        if (w_prod[MUL_W-1:TAG_W] != '0) w_ovf = 1'b1;
                        w_acc     = w_prod[TAG_W-1:0];
                        w_has_dig = 1'b1;
                    end else if (w_byte == SEP_CHAR) begin
                        if (!w_has_dig || w_ovf) begin
                            w_err = 1'b1;
`ifdef FIX_SCAN_CHECKSUM_EN
                            w_t10 = 1'b0;
`endif
                        end else begin
                            if (!w_tag_vld) w_tag = w_acc;
                            w_tag_vld = 1'b1;
                            w_tag_cnt = w_tag_cnt + IDX_W'(1);
`ifdef FIX_SCAN_CHECKSUM_EN
                            w_t10 = (w_acc == TAG_W'(10));
`endif
                        end
                        w_state   = ST_VALUE;
                        w_acc     = '0;
                        w_has_dig = 1'b0;
                        w_ovf     = 1'b0;
                    end else begin
                        w_err     = 1'b1;
                        w_state   = ST_TAG;
                        w_acc     = '0;
                        w_has_dig = 1'b0;
                        w_ovf     = 1'b0;
                    end
                end else if (w_byte == SOH_CHAR) begin
                    w_state = ST_TAG;
`ifdef FIX_SCAN_CHECKSUM_EN
                    // The SOH closing a tag-10 field restarts the sum after itself
                    if (w_t10) w_sum = '0;
                    w_t10 = 1'b0;
`endif
                end else begin
                    w_val_mask[i] = 1'b1;
                end
            end
        end
    end

    // Parse context and output stage advance only on accepted beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_TAG;
            r_acc      <= '0;
            r_has_dig  <= 1'b0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_soh_mask <= '0;
            r_sep_mask <= '0;
            r_soh_idx  <= IDX_NONE;
            r_sep_idx  <= IDX_NONE;
            r_tag_mask <= '0;
            r_val_mask <= '0;
            r_tag_vld  <= 1'b0;
            r_tag      <= '0;
            r_tag_cnt  <= '0;
            r_err      <= 1'b0;
`ifdef FIX_SCAN_CHECKSUM_EN
            r_sum      <= '0;
            r_t10      <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state    <= w_state;
            r_acc      <= w_acc;
            r_has_dig  <= w_has_dig;
            r_ovf      <= w_ovf;
            r_valid    <= 1'b1;
            r_soh_mask <= w_soh_mask;
            r_sep_mask <= w_sep_mask;
            r_soh_idx  <= w_soh_idx;
            r_sep_idx  <= w_sep_idx;
            r_tag_mask <= w_tag_mask;
            r_val_mask <= w_val_mask;
            r_tag_vld  <= w_tag_vld;
            r_tag      <= w_tag;
            r_tag_cnt  <= w_tag_cnt;
            r_err      <= r_err | w_err;
`ifdef FIX_SCAN_CHECKSUM_EN
            r_sum      <= w_sum;
            r_t10      <= w_t10;
`endif
        end else if (bus.ready_i) begin
            r_valid    <= 1'b0;
        end
    end

    assign bus.ready_o       = w_ready;
    assign bus.valid_o       = r_valid;
    assign bus.soh_mask_o    = r_soh_mask;
    assign bus.sep_mask_o    = r_sep_mask;
    assign bus.soh_idx_o     = r_soh_idx;
    assign bus.sep_idx_o     = r_sep_idx;
    assign bus.tag_mask_o    = r_tag_mask;
    assign bus.val_mask_o    = r_val_mask;
    assign bus.tag_vld_o     = r_tag_vld;
    assign bus.tag_o         = r_tag;
    assign bus.tag_cnt_o     = r_tag_cnt;
    assign bus.tag_status_o  = (r_state == ST_TAG);
    assign bus.body_status_o = (r_state == ST_VALUE);
    assign bus.err_o         = r_err;
`ifdef FIX_SCAN_CHECKSUM_EN
    assign bus.chksum_o      = r_sum;
`endif
endmodule

// File: tb/tb_fix_field_scanner.sv
// Bench for fix_field_scanner (LANES=8): directed scenarios then random beats vs. a stream-level model.
// Checks chksum_o as well when FIX_SCAN_CHECKSUM_EN is defined.
module tb_fix_field_scanner;
    localparam int unsigned LANES = 8;
    localparam int unsigned TAG_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fix_field_scanner_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

    fix_field_scanner #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Stream-level model of the parser
    bit     m_in_value;
    longint m_val;
    int     m_ndig;
    bit     m_big;
    bit     m_err;
    bit     m_t10;
    int     m_sum;

    // Expected outputs for the most recent accepted beat
    logic [7:0]  e_soh_mask, e_sep_mask, e_tag_mask, e_val_mask;
    logic [3:0]  e_soh_idx, e_sep_idx;
    logic [15:0] e_tag;
    int          e_cnt;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_value = 0; m_val = 0; m_ndig = 0; m_big = 0;
        m_err = 0; m_t10 = 0; m_sum = 0;
    endtask

    task automatic model_beat(input logic [63:0] d, input logic [7:0] k);
        logic [7:0] b;
        e_soh_mask = '0; e_sep_mask = '0; e_tag_mask = '0; e_val_mask = '0;
        e_soh_idx = 4'hF; e_sep_idx = 4'hF; e_tag = '0; e_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                b = d[8*i +: 8];
                m_sum = (m_sum + int'(b)) % 256;
                if (b == 8'h01) begin
                    e_soh_mask[i] = 1'b1;
                    if (e_soh_idx == 4'hF) e_soh_idx = 4'(i);
                end
                if (b == 8'h3D) begin
                    e_sep_mask[i] = 1'b1;
                    if (e_sep_idx == 4'hF) e_sep_idx = 4'(i);
                end
                if (!m_in_value) begin
                    if (b >= 8'h30 && b <= 8'h39) begin
                        e_tag_mask[i] = 1'b1;
                        m_ndig++;
                        if (!m_big) begin
                            m_val = m_val * 10 + longint'(b - 8'h30);
                            if (m_val > 65535) m_big = 1;
                        end
                    end else if (b == 8'h3D) begin
                        if (m_ndig == 0 || m_big) begin
                            m_err = 1; m_t10 = 0;
                        end else begin
                            if (e_cnt == 0) e_tag = 16'(m_val);
                            e_cnt++;
                            m_t10 = (m_val == 10);
                        end
                        m_in_value = 1; m_val = 0; m_ndig = 0; m_big = 0;
                    end else begin
                        m_err = 1; m_val = 0; m_ndig = 0; m_big = 0;
                    end
                end else if (b == 8'h01) begin
                    m_in_value = 0;
                    if (m_t10) begin m_sum = 0; m_t10 = 0; end
                end else begin
                    e_val_mask[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_out(input string ctx);
        chk({ctx, ".valid"},    32'(bus.valid_o),       1);
        chk({ctx, ".soh_mask"}, 32'(bus.soh_mask_o),    32'(e_soh_mask));
        chk({ctx, ".sep_mask"}, 32'(bus.sep_mask_o),    32'(e_sep_mask));
        chk({ctx, ".soh_idx"},  32'(bus.soh_idx_o),     32'(e_soh_idx));
        chk({ctx, ".sep_idx"},  32'(bus.sep_idx_o),     32'(e_sep_idx));
        chk({ctx, ".tag_mask"}, 32'(bus.tag_mask_o),    32'(e_tag_mask));
        chk({ctx, ".val_mask"}, 32'(bus.val_mask_o),    32'(e_val_mask));
        chk({ctx, ".tag_vld"},  32'(bus.tag_vld_o),     32'(e_cnt != 0));
        chk({ctx, ".tag_cnt"},  32'(bus.tag_cnt_o),     32'(e_cnt));
        if (e_cnt != 0) chk({ctx, ".tag"}, 32'(bus.tag_o), 32'(e_tag));
        chk({ctx, ".tag_st"},   32'(bus.tag_status_o),  32'(!m_in_value));
        chk({ctx, ".body_st"},  32'(bus.body_status_o), 32'(m_in_value));
        chk({ctx, ".err"},      32'(bus.err_o),         32'(m_err));
`ifdef FIX_SCAN_CHECKSUM_EN
        chk({ctx, ".chksum"},   32'(bus.chksum_o),      32'(m_sum));
`endif
    endtask

    task automatic send_raw(input string ctx, input logic [63:0] d, input logic [7:0] k);
        int guard = 0;
        while (!bus.ready_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({ctx, ".ready_wait"}, 32'(guard < 50), 1);
        bus.data_i  = d;
        bus.keep_i  = k;
        bus.valid_i = 1'b1;
        model_beat(d, k);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        check_out(ctx);
    endtask

    // '|' stands for SOH; lanes beyond the string are unkept random filler
    task automatic send(input string s);
        logic [63:0] d;
        logic [7:0]  k;
        d = {$urandom, $urandom};
        k = '0;
        for (int i = 0; i < s.len(); i++) begin
            d[8*i +: 8] = (s[i] == "|") ? 8'h01 : s[i];
            k[i] = 1'b1;
        end
        send_raw(s, d, k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst.valid",  32'(bus.valid_o),      0);
        chk("rst.tag_st", 32'(bus.tag_status_o), 1);
        chk("rst.err",    32'(bus.err_o),        0);
    endtask

    function automatic logic [7:0] rnd_byte();
        int unsigned r = $urandom_range(0, 9);
        case (r)
            0, 1, 2, 3: return 8'(8'h30 + $urandom_range(0, 9));
            4:          return 8'h3D;
            5:          return 8'h01;
            6, 7, 8:    return 8'(8'h41 + $urandom_range(0, 25));
            default:    return 8'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  k;
        int unsigned n;

        bus.data_i = '0; bus.keep_i = '0; bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid",    32'(bus.valid_o),       0);
        chk("reset.soh_mask", 32'(bus.soh_mask_o),    0);
        chk("reset.tag_mask", 32'(bus.tag_mask_o),    0);
        chk("reset.soh_idx",  32'(bus.soh_idx_o),     32'hF);
        chk("reset.sep_idx",  32'(bus.sep_idx_o),     32'hF);
        chk("reset.tag",      32'(bus.tag_o),         0);
        chk("reset.tag_vld",  32'(bus.tag_vld_o),     0);
        chk("reset.tag_cnt",  32'(bus.tag_cnt_o),     0);
        chk("reset.tag_st",   32'(bus.tag_status_o),  1);
        chk("reset.body_st",  32'(bus.body_status_o), 0);
        chk("reset.err",      32'(bus.err_o),         0);
        rst = 1'b0;

        // Basic field across two four-byte beats
        send("8=FI");
        chk("plan1.tag",      32'(bus.tag_o),      8);
        chk("plan1.sep_idx",  32'(bus.sep_idx_o),  1);
        chk("plan1.tag_mask", 32'(bus.tag_mask_o), 32'h1);
        chk("plan1.val_mask", 32'(bus.val_mask_o), 32'hC);
        send("X.4|");
        chk("plan1b.soh_idx", 32'(bus.soh_idx_o),    3);
        chk("plan1b.tag_st",  32'(bus.tag_status_o), 1);

        // Tag split across beats
        send("3");
        chk("split.tag_vld", 32'(bus.tag_vld_o), 0);
        send("5=A|");
        chk("split.tag", 32'(bus.tag_o), 35);

        // Two fields in one word
        send("1=A|2=B|");
        chk("two.tag_cnt",  32'(bus.tag_cnt_o),  2);
        chk("two.tag",      32'(bus.tag_o),      1);
        chk("two.sep_mask", 32'(bus.sep_mask_o), 32'h22);
        chk("two.soh_mask", 32'(bus.soh_mask_o), 32'h88);

        // Empty keep, tag-10 checksum restart, largest legal tag
        send("");
        send("10=ab|5=");
        send("xy|");
        send("6553");
        send("5=x|");
        chk("max.tag", 32'(bus.tag_o), 65535);
        send("65536=|");
        chk("ovf.err", 32'(bus.err_o), 1);

        // Separator at stream start, err stays sticky
        do_reset();
        send("=AB|");
        chk("sep_first.err", 32'(bus.err_o), 1);
        send("7=Q|");
        chk("sticky.err", 32'(bus.err_o), 1);

        // Non-digit in tag
        do_reset();
        send("X=");
        chk("xeq.err", 32'(bus.err_o), 1);

        // Reset mid-value drops the in-flight beat
        do_reset();
        send("1=AB");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("midrst.valid",  32'(bus.valid_o),      0);
        chk("midrst.tag_st", 32'(bus.tag_status_o), 1);
        send("9=");
        chk("midrst.tag", 32'(bus.tag_o), 9);
        send("zz|");
        chk("midrst.err", 32'(bus.err_o), 0);

        // Backpressure: stall three cycles with the next beat held
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        d = 64'h0;
        d[31:0] = 32'h413D_3231;           // "12=A"
        k = 8'h0F;
        bus.data_i = d; bus.keep_i = k; bus.valid_i = 1'b1;
        chk("bp.ready_first", 32'(bus.ready_o), 1);
        model_beat(d, k);
        @(posedge clk); #1;
        d[31:0] = 32'h3701_4342;           // "BC" SOH "7"
        bus.data_i = d;
        for (int c = 0; c < 3; c++) begin
            chk("bp.ready_low", 32'(bus.ready_o), 0);
            check_out("bp.hold");
            @(posedge clk); #1;
        end
        chk("bp.ready_low", 32'(bus.ready_o), 0);
        check_out("bp.hold");
        bus.ready_i = 1'b1;
        #1;
        chk("bp.ready_back", 32'(bus.ready_o), 1);
        model_beat(d, k);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        check_out("bp.next");

        // Random beats with periodic resets
        for (int b = 0; b < 300; b++) begin
            if (b % 50 == 0) do_reset();
            n = $urandom_range(0, 8);
            k = 8'((16'd1 << n) - 16'd1);
            d = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) if (k[i]) d[8*i +: 8] = rnd_byte();
            send_raw("rnd", d, k);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
